key_event_arbiter: RTL
======================

Name: key_event_arbiter

Overview:
- Sits downstream of N per-key debouncers; consumes each debouncer's debounced level and one-cycle valid flag.
- Classifies every key into press / long-press / release events and arbitrates simultaneous events round-robin.
- Queues events in a small FIFO and presents them to one consumer (UI FSM, UART reporter) over a valid/ready handshake.
- Keys are active-low: debounced value 0 = pressed.

Parameters:
- N_KEYS, 4, number of debounced keys (2..16).
- KEY_W, 2, width of key index; must equal ceil(log2(N_KEYS)).
- LONG_CYC, 50_000_000, cycles of continuous press before a LONG event (500 ms at 100 MHz).
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > LONG_CYC.
- FIFO_DEPTH, 4, event FIFO depth; power of two, at least 2.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_value  in  N_KEYS  debounced key levels, bit i = key i.
- key_flag  in  N_KEYS  one-cycle pulse per key: key_value[i] is newly valid.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_key  out  KEY_W  key index of the head event.
- evt_type  out  2  event type: 00 PRESS, 01 LONG, 10 RELEASE; 11 is never emitted.
- evt_drop  out  1  one-cycle pulse when any event is lost.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous via sys_rst_n low:
  - Outputs: evt_valid=0, evt_key=0, evt_type=0, evt_drop=0, fifo_level=0.
  - Every tracker IDLE with counter 0, all pending slots empty, round-robin pointer 0.
  - A reset mid-hold discards the hold; no RELEASE is emitted afterwards.
- Per-key tracker FSM, states IDLE / PRESSED / HELD:
  - IDLE: key_flag=1 with key_value=0 -> PRESSED, counter cleared to 0, post PRESS.
  - PRESSED: counter increments each cycle. On counter==LONG_CYC-1 -> HELD and post LONG. key_flag=1 with key_value=1 -> IDLE and post RELEASE; RELEASE wins if it coincides with the terminal count.
  - HELD: counter frozen. key_flag=1 with key_value=1 -> IDLE and post RELEASE.
  - Any key_flag whose value matches the current state is ignored: value 1 in IDLE, value 0 in PRESSED/HELD.
  - key_value without key_flag is never sampled.
- Pending slots: one slot per key, holding the type.
  - A post into an empty slot, or into a slot granted in that same cycle, succeeds.
  - A post into an occupied, ungranted slot is discarded; evt_drop pulses for one cycle and the older event is kept.
- Arbiter:
  - Each cycle, if fifo_level < FIFO_DEPTH (registered value; a same-cycle pop does not free space), grant one pending key.
  - Search starts at the round-robin pointer and wraps modulo N_KEYS.
  - The granted slot is cleared and {key, type} is written to the FIFO.
  - After a grant the pointer becomes granted index + 1, wrapping to 0.
  - If nothing is pending or the FIFO is full, no grant occurs and the pointer holds.
- FIFO:
  - evt_valid = fifo_level != 0; evt_key and evt_type always show the head.
  - Pop on evt_valid & evt_ready. evt_ready while empty has no effect.
  - Simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap at FIFO_DEPTH.
- Latency: key_flag sampled at edge t -> slot set at t -> FIFO write at t+1 -> evt_valid high after edge t+1. Minimum is 2 cycles when the FIFO is empty and there is no contention.
- evt_drop also pulses if a slot-to-FIFO transfer is ever blocked long enough to lose a post. The FIFO itself never overflows.

Decomposition:
- Package key_evt_pkg:
  - Event-type constants EVT_PRESS, EVT_LONG, EVT_RELEASE.
  - Tracker state encodings.
  - Function computing KEY_W.
- Sub-module key_evt_fifo:
  - Synchronous FIFO, parameters FIFO_DEPTH and width KEY_W+2.
  - Ports: push, pop, din, dout, level, with the same clock and reset.
- Trackers, pending slots and the arbiter stay in the top module, using a generate loop over N_KEYS.

Test Plan:
- Single short press:
  - Stimulus: key_flag[1] with value 0 at cycle 10; flag with value 1 at cycle 1000; evt_ready=1; LONG_CYC=100 for sim.
  - Response: PRESS/key 1 valid at cycle 12; RELEASE/key 1 valid at cycle 1002; no LONG; evt_drop never pulses.
- Long press:
  - Stimulus: key 2 pressed at cycle 0 and held; LONG_CYC=100.
  - Response: PRESS, then LONG exactly 100 cycles after the press posts, then a single RELEASE on release; the LONG is not repeated.
- Simultaneous press:
  - Stimulus: flags for keys 0..3 in the same cycle, pointer at 0, evt_ready=1.
  - Response: PRESS events in order 0,1,2,3 on consecutive cycles. A second round starting with pointer at 2 gives order 2,3,0,1.
- Back-pressure:
  - Stimulus: evt_ready=0, FIFO_DEPTH=4, 5 keys' presses (N_KEYS=5).
  - Response: fifo_level saturates at 4 and the fifth event waits in its slot. After evt_ready=1, all 5 events drain in round-robin order with no drop.
- Drop:
  - Stimulus: FIFO full, key 0 pressed then released while the PRESS is still pending.
  - Response: evt_drop pulses once; PRESS for key 0 is later delivered; the RELEASE is lost.
- Reset mid-hold:
  - Stimulus: key 3 in HELD; assert sys_rst_n low for 3 cycles; release key 3 after reset.
  - Response: all outputs 0 during reset; the post-reset release flag is ignored, since the tracker is IDLE and value=1.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared constants, tracker state encoding and sizing helper for the key event arbiter.
package key_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_LONG    = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    TrkIdle    = 2'b00,
    TrkPressed = 2'b01,
    TrkHeld    = 2'b10
  } trk_state_e;

  // Width of a key index for n_keys keys (never below one bit).
  function automatic int unsigned key_w(input int unsigned n_keys);
    return (n_keys < 2) ? 1 : $clog2(n_keys);
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous event FIFO; head is always visible on dout_o.
module key_evt_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              din_i,
  output logic [WIDTH-1:0]              dout_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  // Never write when full, never read when empty.
  assign do_push = push_i && (level_q != LvlW'(FIFO_DEPTH));
  assign do_pop  = pop_i && (level_q != '0);

  // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Turns debounced key levels into PRESS/LONG/RELEASE events, arbitrates them
// round-robin and queues them for a single valid/ready consumer.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned KEY_W      = key_w(N_KEYS),
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [N_KEYS-1:0]             key_value,
  input  logic [N_KEYS-1:0]             key_flag,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [KEY_W-1:0]              evt_key,
  output logic [1:0]                    evt_type,
  output logic                          evt_drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IdxW = KEY_W + 1;

  logic [N_KEYS-1:0] slot_vld;
  logic [1:0]        slot_type [N_KEYS];
  logic [N_KEYS-1:0] gnt;
  logic [N_KEYS-1:0] drop_vec;
  logic              gnt_any;
  logic [KEY_W-1:0]  gnt_idx;
  logic [1:0]        gnt_type;
  logic [KEY_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              drop_q;
  logic [KEY_W+1:0]  head;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    trk_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             post;
    logic [1:0]       post_type;
    logic             slot_vld_q, slot_vld_d;
    logic [1:0]       slot_type_q, slot_type_d;
    logic             drop;

    // Tracker: flags agreeing with the current state are ignored.
    always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      post      = 1'b0;
      post_type = EVT_PRESS;
      unique case (st_q)
        TrkIdle: begin
          if (key_flag[i] && !key_value[i]) begin
            st_d  = TrkPressed;
            cnt_d = '0;
            post  = 1'b1;
          end
        end
        TrkPressed: begin
          // Release takes priority over a coincident terminal count.
          if (key_flag[i] && key_value[i]) begin
            st_d      = TrkIdle;
            cnt_d     = '0;
            post      = 1'b1;
            post_type = EVT_RELEASE;
          end else if (cnt_q == CNT_W'(LONG_CYC - 1)) begin
            st_d      = TrkHeld;
            post      = 1'b1;
            post_type = EVT_LONG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TrkHeld: begin
          if (key_flag[i] && key_value[i]) begin
            st_d      = TrkIdle;
            cnt_d     = '0;
            post      = 1'b1;
            post_type = EVT_RELEASE;
          end
        end
        default: st_d = TrkIdle;
      endcase
    end

    // Pending slot: a post may refill a slot being granted this cycle; else it is dropped.
    always_comb begin
      slot_vld_d  = slot_vld_q;
      slot_type_d = slot_type_q;
      drop        = 1'b0;
      if (gnt[i]) slot_vld_d = 1'b0;
      if (post) begin
        if (!slot_vld_q || gnt[i]) begin
          slot_vld_d  = 1'b1;
          slot_type_d = post_type;
        end else begin
          drop = 1'b1;
        end
      end
    end

    // Tracker and slot registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        st_q        <= TrkIdle;
        cnt_q       <= '0;
        slot_vld_q  <= 1'b0;
        slot_type_q <= EVT_PRESS;
      end else begin
        st_q        <= st_d;
        cnt_q       <= cnt_d;
        slot_vld_q  <= slot_vld_d;
        slot_type_q <= slot_type_d;
      end
    end

    assign slot_vld[i]  = slot_vld_q;
    assign slot_type[i] = slot_type_q;
    assign drop_vec[i]  = drop;
  end

  // Round-robin grant from rr_ptr_q; only when the registered level shows free space.
  always_comb begin : p_arb
    logic [IdxW-1:0] idx;
    idx      = '0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    if (fifo_level < LvlW'(FIFO_DEPTH)) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        idx = {1'b0, rr_ptr_q} + IdxW'(k);
        if (idx >= IdxW'(N_KEYS)) idx = idx - IdxW'(N_KEYS);
        if (!gnt_any && slot_vld[idx[KEY_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = idx[KEY_W-1:0];
        end
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      rr_ptr_d     = (gnt_idx == KEY_W'(N_KEYS - 1)) ? '0 : gnt_idx + KEY_W'(1);
    end
  end

  assign gnt_type = slot_type[gnt_idx];

  // Round-robin pointer and registered drop pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= |drop_vec;
    end
  end

  key_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (KEY_W + 2)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (gnt_any),
    .pop_i   (evt_ready),
    .din_i   ({gnt_idx, gnt_type}),
    .dout_o  (head),
    .level_o (fifo_level)
  );

  assign evt_valid = (fifo_level != '0);
  assign evt_key   = head[KEY_W+1:2];
  assign evt_type  = head[1:0];
  assign evt_drop  = drop_q;

endmodule
